imem_responder: RTL
===================

IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 Parameter: TIMEOUT, default 255; max BUS cycles waited for mem_ack before a fault response.
REQ-002 Parameter: NOP_INSTR, default 32'h0000_0013; instruction returned on any fault.
REQ-003 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port: RST  input  1  reset, asynchronous, active-high.
REQ-005 Port: PCaddr  input  32  fetch address from the PC; held stable while iready=0.
REQ-006 Port: flush  input  1  invalidates the one-entry instruction buffer.
REQ-007 Port: iready  output  1  one-cycle pulse: instr/ifault valid for current PCaddr; PC advances on it.
REQ-008 Port: instr  output  32  fetched instruction, registered.
REQ-009 Port: ifault  output  1  registered; set when instr is NOP_INSTR due to misalignment or timeout.
REQ-010 Port: mem_ren  output  1  backing-memory read request, high only in BUS.
REQ-011 Port: mem_addr  output  32  word-aligned latched address ({addr[31:2],2'b00}), valid while mem_ren=1.
REQ-012 Port: mem_rdata  input  32  backing-memory read data, sampled only when mem_ack=1 in BUS.
REQ-013 Port: mem_ack  input  1  backing-memory completion; ignored outside BUS.

Function
REQ-014 States: IDLE, LOOKUP, BUS, RESP; IDLE -> LOOKUP unconditionally.
REQ-015 LOOKUP, PCaddr[1:0]!=0: instr<=NOP_INSTR, ifault<=1, -> RESP; no bus request; buffer unchanged.
REQ-016 LOOKUP, aligned, valid=1 and PCaddr[31:2]==tag: hit, instr unchanged, ifault<=0, -> RESP.
REQ-017 LOOKUP, aligned miss: addr_q<=PCaddr, timeout counter<=0, -> BUS.
REQ-018 BUS with mem_ack=1: instr<=mem_rdata, tag<=addr_q[31:2], valid<=1, ifault<=0, -> RESP.
REQ-019 BUS with mem_ack=0: counter increments; when counter reaches TIMEOUT-1 with no ack: instr<=NOP_INSTR, ifault<=1, valid<=0, -> RESP, mem_ren drops next cycle.
REQ-020 RESP: iready=1 for exactly one cycle, -> LOOKUP; iready=0 in every other state.
REQ-021 Latency from LOOKUP entry: hit or misalignment -> iready 1 cycle later; miss with ack in k-th BUS cycle (k>=1) -> iready k+1 cycles later.
REQ-022 flush=1 clears valid on that edge in any state; flush coincident with mem_ack in BUS: instr still delivered with ifault=0, valid stays 0.
REQ-023 flush coincident with a hit in LOOKUP: the hit is honoured this lookup; valid=0 afterward.
REQ-024 Counter is 8 bits minimum and sized from TIMEOUT; it never wraps, saturating at TIMEOUT-1.
REQ-025 mem_addr and mem_ren are driven from state and addr_q only, never combinationally from PCaddr.

Reset
REQ-026 RST=1 forces, asynchronously: state=IDLE, iready=0, instr=NOP_INSTR, ifault=0, valid=0, tag=0, addr_q=0, counter=0, mem_ren=0.
REQ-027 RST during BUS abandons the request; a late mem_ack after reset release is ignored unless state is BUS.

Structure
REQ-028 Shared package cpu_pkg holds the fetch-state enum (FS_IDLE, FS_LOOKUP, FS_BUS, FS_RESP) and the NOP_INSTR constant 32'h0000_0013.
REQ-029 Single module, no sub-module; one sequential block for registers, one combinational block for next-state and outputs.

Verification
REQ-030 Reset then PCaddr=0, mem_ack on first BUS cycle with rdata=32'h00500093 -> mem_addr=0, iready pulses on cycle 3 after reset release, instr=32'h00500093, ifault=0.
REQ-031 PCaddr held at 0x0000_0040 across two lookups, ack after 4 cycles first time -> first iready after 5 cycles, second iready 1 cycle after LOOKUP, mem_ren stays 0 on second.
REQ-032 PCaddr=0x0000_0042 -> iready 1 cycle after LOOKUP, instr=0x00000013, ifault=1, mem_ren never asserted.
REQ-033 TIMEOUT=4, mem_ack held 0 -> mem_ren high exactly 4 cycles, then iready with instr=0x00000013, ifault=1; next lookup to same address misses.
REQ-034 flush coincident with mem_ack (rdata=0xDEADBEEF) -> iready with instr=0xDEADBEEF, ifault=0; repeat lookup of same address re-issues mem_ren.
REQ-035 RST asserted in the middle of BUS, mem_ack pulsed one cycle after release -> iready stays 0, instr=0x00000013, state restarts at IDLE.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction-fetch state encoding and the canonical NOP.
package cpu_pkg;

  typedef enum logic [1:0] {
    FS_IDLE,
    FS_LOOKUP,
    FS_BUS,
    FS_RESP
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/imem_responder.sv
// Instruction-fetch responder: one-entry instruction buffer in front of a
// handshaked backing memory, with misalignment and timeout fault reporting.
module imem_responder #(
  parameter int unsigned TIMEOUT   = 255,
  parameter logic [31:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        RST,
  input  logic [31:0] PCaddr,
  input  logic        flush,
  output logic        iready,
  output logic [31:0] instr,
  output logic        ifault,
  output logic        mem_ren,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);
  import cpu_pkg::*;

  localparam int unsigned CW = ($clog2(TIMEOUT) > 8) ? $clog2(TIMEOUT) : 8;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  fetch_state_t  state_q, state_n;
  logic [31:0]   instr_q, instr_n;
  logic          ifault_q, ifault_n;
  logic          valid_q, valid_n;
  logic [29:0]   tag_q, tag_n;
  logic [31:0]   addr_q, addr_n;
  logic [CW-1:0] cnt_q, cnt_n;

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_q  <= FS_IDLE;
      instr_q  <= NOP_INSTR;
      ifault_q <= 1'b0;
      valid_q  <= 1'b0;
      tag_q    <= '0;
      addr_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_n;
      instr_q  <= instr_n;
      ifault_q <= ifault_n;
      valid_q  <= valid_n;
      tag_q    <= tag_n;
      addr_q   <= addr_n;
      cnt_q    <= cnt_n;
    end
  end

  always_comb begin
    state_n  = state_q;
    instr_n  = instr_q;
    ifault_n = ifault_q;
    valid_n  = valid_q;
    tag_n    = tag_q;
    addr_n   = addr_q;
    cnt_n    = cnt_q;
    iready   = 1'b0;
    mem_ren  = 1'b0;
    mem_addr = {addr_q[31:2], 2'b00};

    case (state_q)
      FS_IDLE: state_n = FS_LOOKUP;

      FS_LOOKUP: begin
        if (PCaddr[1:0] != 2'b00) begin
          instr_n  = NOP_INSTR;
          ifault_n = 1'b1;
          state_n  = FS_RESP;
        end else if (valid_q && (PCaddr[31:2] == tag_q)) begin
          // Buffered word is already sitting in instr_q.
          ifault_n = 1'b0;
          state_n  = FS_RESP;
        end else begin
          addr_n  = PCaddr;
          cnt_n   = '0;
          state_n = FS_BUS;
        end
      end

      FS_BUS: begin
        mem_ren = 1'b1;
        if (mem_ack) begin
          instr_n  = mem_rdata;
          tag_n    = addr_q[31:2];
          valid_n  = 1'b1;
          ifault_n = 1'b0;
          state_n  = FS_RESP;
        end else if (cnt_q == CNT_LAST) begin
          instr_n  = NOP_INSTR;
          ifault_n = 1'b1;
          valid_n  = 1'b0;
          state_n  = FS_RESP;
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
      end

      FS_RESP: begin
        iready  = 1'b1;
        state_n = FS_LOOKUP;
      end

      default: state_n = FS_IDLE;
    endcase

    // Flush wins over any fill on the same edge; the in-flight word is still delivered.
    if (flush) valid_n = 1'b0;
  end

  assign instr  = instr_q;
  assign ifault = ifault_q;

endmodule
